axis_h2c_framer: RTL and testbench

AXIS_H2C_FRAMER -- requirements
Module: axis_h2c_framer

---
 rtl/axis_h2c_framer.sv | 129 ++++++++++++
 tb/tb_axis_h2c_framer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_h2c_framer.sv
// axis_h2c_framer: skid-buffered H2C stream pass-through that caps packets at MAX_BEATS
// and keeps packet, split and byte statistics on the input side.
module axis_h2c_framer #(
  parameter int C_DATA_WIDTH = 128,
  parameter int MAX_BEATS    = 256,
  parameter int CNT_WIDTH    = 32,
  localparam int KW  = C_DATA_WIDTH / 8,
  localparam int BW  = $clog2(MAX_BEATS * C_DATA_WIDTH / 8) + 1,
  localparam int BCW = $clog2(MAX_BEATS)
) (
  input  logic                    s_axis_aclk,
  input  logic                    s_axis_aresetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KW-1:0]           s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KW-1:0]           m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH-1:0]    split_count,
  output logic [BW-1:0]           last_pkt_bytes,
  output logic                    busy
);
  logic                    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic                    main_last_q, main_last_d, skid_last_q, skid_last_d;
  logic [C_DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [KW-1:0]           main_keep_q, main_keep_d, skid_keep_q, skid_keep_d;
  logic                    ready_q, ready_d;
  logic [BCW-1:0]          beat_q, beat_d;
  logic [BW-1:0]           acc_q, acc_d, last_bytes_q, last_bytes_d, pop;
  logic [CNT_WIDTH-1:0]    pkt_q, pkt_d, split_q, split_d;
  logic                    accept, xfer, term, done;

  assign accept = s_axis_tvalid & ready_q;
  assign xfer   = main_valid_q & m_axis_tready;
  assign term   = s_axis_tlast | (beat_q == BCW'(MAX_BEATS - 1));
  assign done   = accept & term;

  always_comb begin
    pop = '0;
    for (int i = 0; i < KW; i++) pop = pop + BW'(s_axis_tkeep[i]);
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_keep_d  = main_keep_q;
    main_last_d  = main_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    skid_last_d  = skid_last_q;
    if (skid_valid_q) begin
      if (xfer) begin
        main_data_d  = skid_data_q;
        main_keep_d  = skid_keep_q;
        main_last_d  = skid_last_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept && (!main_valid_q || m_axis_tready)) begin
      main_valid_d = 1'b1;
      main_data_d  = s_axis_tdata;
      main_keep_d  = s_axis_tkeep;
      main_last_d  = term;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis_tdata;
      skid_keep_d  = s_axis_tkeep;
      skid_last_d  = term;
    end else if (xfer) begin
      main_valid_d = 1'b0;
    end
    // ready is registered from the next skid state so it never depends on m_axis_tready combinationally
    ready_d      = ~skid_valid_d;
    beat_d       = accept ? (term ? '0 : beat_q + 1'b1) : beat_q;
    acc_d        = accept ? (term ? '0 : acc_q + pop) : acc_q;
    last_bytes_d = done ? acc_q + pop : last_bytes_q;
    pkt_d        = pkt_q + CNT_WIDTH'(done);
    split_d      = split_q + CNT_WIDTH'(done & ~s_axis_tlast);
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_keep_q  <= '0;
      main_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_last_q  <= 1'b0;
      ready_q      <= 1'b0;
      beat_q       <= '0;
      acc_q        <= '0;
      last_bytes_q <= '0;
      pkt_q        <= '0;
      split_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_keep_q  <= main_keep_d;
      main_last_q  <= main_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_keep_q  <= skid_keep_d;
      skid_last_q  <= skid_last_d;
      ready_q      <= ready_d;
      beat_q       <= beat_d;
      acc_q        <= acc_d;
      last_bytes_q <= last_bytes_d;
      pkt_q        <= pkt_d;
      split_q      <= split_d;
    end
  end

  assign s_axis_tready  = ready_q;
  assign m_axis_tvalid  = main_valid_q;
  assign m_axis_tdata   = main_data_q;
  assign m_axis_tkeep   = main_keep_q;
  assign m_axis_tlast   = main_last_q;
  assign pkt_count      = pkt_q;
  assign split_count    = split_q;
  assign last_pkt_bytes = last_bytes_q;
  assign busy           = main_valid_q | skid_valid_q | (beat_q != '0);
endmodule

// File: tb/tb_axis_h2c_framer.sv
// tb_axis_h2c_framer: directed and randomized checks of axis_h2c_framer against a queue-based
// packet model; outputs are sampled on the falling clock edge.
module tb_axis_h2c_framer;
  localparam int DW = 128;
  localparam int KW = DW / 8;
  localparam int MB = 4;
  localparam int BW = $clog2(MB * KW) + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tready, m_tvalid, m_tlast, busy;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [31:0]   pkt_count, split_count;
  logic [BW-1:0] last_pkt_bytes;

  beat_t exp_q[$];
  int tests = 0, fails = 0;
  int m_pos = 0, m_bytes = 0, m_pkt = 0, m_split = 0, m_last = 0, n_olast = 0;

  always #5 clk = ~clk;

  axis_h2c_framer #(.C_DATA_WIDTH(DW), .MAX_BEATS(MB), .CNT_WIDTH(32)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .pkt_count(pkt_count), .split_count(split_count),
    .last_pkt_bytes(last_pkt_bytes), .busy(busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [KW-1:0] rkeep();
    int r = $urandom_range(3);
    logic [KW-1:0] k = KW'($urandom);
    if (r == 0) k = '0;
    if (r == 1) k = '1;
    return k;
  endfunction

  // Scoreboard: packets are cut at the tlast beat or at the MAX_BEATS-th beat of a packet
  logic          hold = 1'b0, hold_l, term;
  logic [DW-1:0] hold_d;
  logic [KW-1:0] hold_k;
  beat_t         b, e;
  initial forever begin
    @(negedge clk);
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, hold_d);
        chk("hold_keep", m_tkeep, hold_k);
        chk("hold_last", m_tlast, hold_l);
      end
      if (m_tvalid && m_tready) begin
        if (m_tlast) n_olast++;
        chk("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_keep", m_tkeep, e.k);
          chk("out_last", m_tlast, e.l);
        end
      end
      if (s_tvalid && s_tready) begin
        term = s_tlast || (m_pos == MB - 1);
        b.d = s_tdata; b.k = s_tkeep; b.l = term;
        exp_q.push_back(b);
        m_bytes += $countones(s_tkeep);
        if (term) begin
          m_last = m_bytes; m_bytes = 0; m_pkt++; m_pos = 0;
          if (!s_tlast) m_split++;
        end else m_pos++;
      end
      hold = m_tvalid && !m_tready;
      hold_d = m_tdata; hold_k = m_tkeep; hold_l = m_tlast;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_accept();
    logic acc;
    int g = 0;
    do begin acc = s_tready; @(posedge clk); #1; g++; end while (!acc && g < 50);
    chk("accept_in_time", acc, 1);
    s_tvalid = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    wait_accept();
  endtask

  task automatic chk_stats(input string tag, input int p, input int s, input int bytes);
    chk({tag, "_pkt"}, pkt_count, p);
    chk({tag, "_split"}, split_count, s);
    chk({tag, "_bytes"}, last_pkt_bytes, bytes);
  endtask

  task automatic chk_reset();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_split", split_count, 0);
    chk("rst_bytes", last_pkt_bytes, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic run_random(input int n);
    int gen = 0, pidx = 0, cyc = 0;
    int plen = $urandom_range(1, 7);
    logic acc;
    while ((s_tvalid || gen < n || pidx != 0) && cyc < 60000) begin
      if (!s_tvalid && (gen < n || pidx != 0) && $urandom_range(1) == 1) begin
        s_tdata = rnd(); s_tkeep = rkeep(); s_tlast = (pidx == plen - 1); s_tvalid = 1'b1;
        gen++;
        if (s_tlast) begin pidx = 0; plen = $urandom_range(1, 7); end
        else pidx++;
      end
      m_tready = 1'($urandom_range(1));
      acc = s_tvalid && s_tready;
      @(posedge clk); #1; cyc++;
      if (acc) s_tvalid = 1'b0;
    end
    chk("random_complete", cyc < 60000, 1);
  endtask

  logic [DW-1:0] a, bb;
  int g;
  initial begin
    step(2);
    chk_reset();
    rst_n = 1'b1;
    chk("ready_before_edge", s_tready, 0);
    step(1);
    chk("ready_after_edge", s_tready, 1);
    // 4-beat full packet with no backpressure: one-cycle latency
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = rnd();
      push(a, '1, i == 3);
      chk("lat_valid", m_tvalid, 1);
      chk("lat_data", m_tdata, a);
    end
    step(2);
    chk_stats("four_beat", 1, 0, 64);
    chk("four_beat_olast", n_olast, 1);
    // 10 beats, tlast only on the 10th: cuts after beats 4 and 8
    for (int i = 0; i < 10; i++) push(rnd(), '1, i == 9);
    step(2);
    chk_stats("split", 4, 2, 32);
    chk("split_olast", n_olast, 4);
    push(rnd(), 16'h0007, 1'b1);
    step(2);
    chk_stats("one_beat", 5, 2, 3);
    // output stall: two beats absorbed, then input throttled
    m_tready = 1'b0;
    a = rnd(); bb = rnd();
    push(a, '1, 1'b0);
    chk("stall_ready_one", s_tready, 1);
    push(bb, '1, 1'b0);
    chk("stall_ready_two", s_tready, 0);
    chk("stall_busy", busy, 1);
    s_tdata = rnd(); s_tkeep = '1; s_tlast = 1'b1; s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stall_ready_low", s_tready, 0);
      chk("stall_out_data", m_tdata, a);
    end
    m_tready = 1'b1;
    wait_accept();
    step(3);
    chk_stats("stall", 6, 2, 48);
    chk("stall_drained", exp_q.size(), 0);
    chk("stall_idle", busy, 0);
    // reset in the middle of a stalled packet
    m_tready = 1'b0;
    push(rnd(), '1, 1'b0);
    push(rnd(), '1, 1'b0);
    s_tdata = rnd(); s_tvalid = 1'b1;
    step(1);
    rst_n = 1'b0;
    #1;
    chk_reset();
    s_tvalid = 1'b0;
    exp_q.delete();
    m_pos = 0; m_bytes = 0; m_pkt = 0; m_split = 0; m_last = 0;
    step(2);
    chk("rst_hold_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    chk("rel_ready_before_edge", s_tready, 0);
    step(1);
    chk("rel_ready_after_edge", s_tready, 1);
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) push(rnd(), '1, i == 2);
    step(2);
    chk_stats("after_reset", 1, 0, 48);
    chk("after_reset_drained", exp_q.size(), 0);
    // randomized traffic against the model
    run_random(10000);
    m_tready = 1'b1;
    g = 0;
    while (busy && g < 100) begin step(1); g++; end
    step(1);
    chk("rand_idle", busy, 0);
    chk("rand_drained", exp_q.size(), 0);
    chk_stats("rand", m_pkt, m_split, m_last);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
